// File: rtl/csr_pkg.sv
// csr_pkg: definitions shared by the CSR arbiter and its read-modify-write unit.
//   csr_op_e       request operation encoding (READ/WRITE/SET/CLEAR)
//   csr_state_e    arbiter FSM states
//   RO_ADDR_FIELD  top-two-address-bit value marking the read-only CSR region
package csr_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_READ   = 2'b01,
    ST_MODIFY = 2'b10,
    ST_RESP   = 2'b11
  } csr_state_e;

  localparam logic [1:0] RO_ADDR_FIELD = 2'b11;

  // A SET/CLEAR with a zero operand changes nothing, so it is not treated
  // as a write: it is neither written back nor flagged on read-only space.
  function automatic logic is_write_type(input csr_op_e op, input logic operand_nz);
    return (op == OP_WRITE) || (((op == OP_SET) || (op == OP_CLEAR)) && operand_nz);
  endfunction

endpackage

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: combinational read-modify-write datapath.
//   i_op          latched request operation
//   i_old         current CSR value (csr_rdata during MODIFY)
//   i_wdata       latched write/set/clear operand
//   i_addr_field  top two bits of the latched CSR address
//   o_new         value to write back
//   o_wr_en       write-back allowed
//   o_err         write-type access to the read-only region
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  csr_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]            i_addr_field,
  output logic [DATA_WIDTH-1:0] o_new,
  output logic                  o_wr_en,
  output logic                  o_err
);

  logic w_write_type;
  logic w_read_only;

  always_comb begin
    o_new = i_old;
    case (i_op)
      OP_WRITE: o_new = i_wdata;
      OP_SET:   o_new = i_old | i_wdata;
      OP_CLEAR: o_new = i_old & ~i_wdata;
      default:  o_new = i_old;
    endcase
  end

  assign w_write_type = is_write_type(i_op, |i_wdata);
  assign w_read_only  = (i_addr_field == RO_ADDR_FIELD);
  assign o_wr_en      = w_write_type && !w_read_only;
  assign o_err        = w_write_type && w_read_only;

endmodule

// File: rtl/csr_arbiter.sv
// csr_arbiter: two-port (0 = pipeline, 1 = debug) arbiter in front of a CSR
// file, performing one read-modify-write at a time.
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/op/addr/wdata      request from port N
//   reqN_ready                    one-cycle acceptance pulse for port N
//   rspN_valid/ready/rdata/err    response to port N (rdata = old CSR value)
//   csr_rd_en, csr_addr           CSR file read strobe and address
//   csr_rdata                     CSR read data, valid one cycle after csr_rd_en
//   csr_wr_en, csr_wdata          CSR file write strobe and data
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a request; grants one port and latches it
// ST_READ   | csr_rd_en asserted for the latched address
// ST_MODIFY | csr_rdata captured as old; write-back issued if allowed
// ST_RESP   | response held on the granted port until rspN_ready
module csr_arbiter
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [1:0]            req0_op,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [1:0]            req1_op,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  csr_rd_en,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_wr_en,
  output logic [DATA_WIDTH-1:0] csr_wdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  csr_state_e            r_state;
  csr_state_e            w_state_nxt;
  csr_op_e               r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_old;
  logic                  r_port;
  logic                  r_err;
  logic [CNT_W-1:0]      r_starve;

  logic                  w_any_req;
  logic                  w_grant1;
  logic [DATA_WIDTH-1:0] w_new;
  logic                  w_wr_en;
  logic                  w_err;

  assign w_any_req = req0_valid || req1_valid;
  // Port 1 wins only when port 0 is idle or has used up its starvation budget.
  assign w_grant1  = req1_valid && (!req0_valid || (r_starve == LIMIT_C));

  csr_rmw_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rmw (
    .i_op         (r_op),
    .i_old        (csr_rdata),
    .i_wdata      (r_wdata),
    .i_addr_field (r_addr[ADDR_WIDTH-1 -: 2]),
    .o_new        (w_new),
    .o_wr_en      (w_wr_en),
    .o_err        (w_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp0_rdata  = '0;
    rsp0_err    = 1'b0;
    rsp1_valid  = 1'b0;
    rsp1_rdata  = '0;
    rsp1_err    = 1'b0;
    csr_rd_en   = 1'b0;
    csr_addr    = r_addr;
    csr_wr_en   = 1'b0;
    csr_wdata   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_READ;
          req0_ready  = !w_grant1;
          req1_ready  = w_grant1;
        end
      end
      ST_READ: begin
        csr_rd_en   = 1'b1;
        w_state_nxt = ST_MODIFY;
      end
      ST_MODIFY: begin
        csr_wr_en   = w_wr_en;
        csr_wdata   = w_wr_en ? w_new : '0;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (r_port) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = r_old;
          rsp1_err   = r_err;
          if (rsp1_ready) w_state_nxt = ST_IDLE;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = r_old;
          rsp0_err   = r_err;
          if (rsp0_ready) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reset is synchronous, so the FSM may still sit in MODIFY/RESP during
    // the reset cycle; the outputs are forced quiet here so an in-flight
    // request is dropped without a write or a response.
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp0_rdata = '0;
      rsp0_err   = 1'b0;
      rsp1_valid = 1'b0;
      rsp1_rdata = '0;
      rsp1_err   = 1'b0;
      csr_rd_en  = 1'b0;
      csr_addr   = '0;
      csr_wr_en  = 1'b0;
      csr_wdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_old    <= '0;
      r_port   <= 1'b0;
      r_err    <= 1'b0;
      r_starve <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_any_req) begin
        r_port  <= w_grant1;
        r_op    <= w_grant1 ? csr_op_e'(req1_op) : csr_op_e'(req0_op);
        r_addr  <= w_grant1 ? req1_addr : req0_addr;
        r_wdata <= w_grant1 ? req1_wdata : req0_wdata;
        if (w_grant1 || !req1_valid) begin
          r_starve <= '0;
        end else if (r_starve != LIMIT_C) begin
          r_starve <= r_starve + 1'b1;
        end
      end
      if (r_state == ST_MODIFY) begin
        r_old <= csr_rdata;
        r_err <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: directed stimulus with a scoreboard. Stimulus pushes the
// expected grant, write-back and response into queues; a negedge monitor
// pops and compares whenever the DUT presents the corresponding event.
module tb_csr_arbiter;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [11:0] req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        rsp0_err, rsp1_err;
  logic        csr_rd_en, csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, csr_wdata;

  always #5 clk = ~clk;

  csr_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (12),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .csr_rd_en  (csr_rd_en),
    .csr_addr   (csr_addr),
    .csr_rdata  (csr_rdata),
    .csr_wr_en  (csr_wr_en),
    .csr_wdata  (csr_wdata)
  );

  // CSR file model: registered read, write port shared with a preload path.
  logic [31:0] mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (csr_wr_en) mem[csr_addr] <= csr_wdata;
    if (csr_rd_en) csr_rdata <= mem[csr_addr];
  end

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t exp_rsp[$];
  wr_t  exp_wr[$];
  logic exp_grant[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic p, input logic [31:0] d, input logic e);
    rsp_t r;
    r.port  = p;
    r.rdata = d;
    r.err   = e;
    return r;
  endfunction

  function automatic wr_t mk_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Monitor
  int          t_acc = 0;
  bit          resp_seen = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready || req1_ready) begin
        check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
        check("ready_during_rsp", 64'(rsp0_valid | rsp1_valid), 64'd0);
        if (exp_grant.size() == 0) check("unexpected_grant", 64'd1, 64'd0);
        else check("grant_port", 64'(req1_ready), 64'(exp_grant.pop_front()));
        t_acc     = cyc;
        resp_seen = 1'b0;
      end
      if (csr_rd_en) begin
        check("rd_latency", 64'(cyc), 64'(t_acc + 1));
        check("rd_wr_exclusive", 64'(csr_wr_en), 64'd0);
      end
      if (csr_wr_en) begin
        check("wr_latency", 64'(cyc), 64'(t_acc + 2));
        if (exp_wr.size() == 0) begin
          check("unexpected_wr", 64'd1, 64'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", 64'(csr_addr), 64'(w.addr));
          check("wr_data", 64'(csr_wdata), 64'(w.data));
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        logic        p;
        logic [31:0] rd;
        logic        er;
        logic        rdy;
        p   = rsp1_valid;
        rd  = p ? rsp1_rdata : rsp0_rdata;
        er  = p ? rsp1_err : rsp0_err;
        rdy = p ? rsp1_ready : rsp0_ready;
        check("rsp_onehot", 64'(rsp0_valid & rsp1_valid), 64'd0);
        check("other_port_zero", p ? 64'({rsp0_rdata, rsp0_err}) : 64'({rsp1_rdata, rsp1_err}), 64'd0);
        if (!resp_seen) begin
          check("rsp_latency", 64'(cyc), 64'(t_acc + 3));
          resp_seen = 1'b1;
        end else begin
          check("rsp_stable_rdata", 64'(rd), 64'(prev_rdata));
          check("rsp_stable_err", 64'(er), 64'(prev_err));
        end
        prev_rdata = rd;
        prev_err   = er;
        if (rdy) begin
          if (exp_rsp.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            rsp_t r;
            r = exp_rsp.pop_front();
            check("rsp_port", 64'(p), 64'(r.port));
            check("rsp_rdata", 64'(rd), 64'(r.rdata));
            check("rsp_err", 64'(er), 64'(r.err));
          end
        end
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic issue(input bit port, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (port) begin
      req1_op = op; req1_addr = a; req1_wdata = wd; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_addr = a; req0_wdata = wd; req0_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    if (port) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    if (!ok) check("issue_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (exp_rsp.size() == 0 && exp_wr.size() == 0 && exp_grant.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check("drain_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {12'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                 csr_rd_en, csr_wr_en, csr_addr, csr_wdata}, 64'd0);
    check({name, "_rdata"}, {rsp0_rdata, rsp1_rdata}, 64'd0);
  endtask

  initial begin
    int n;
    logic seq [10];
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = OP_RD; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_op = OP_RD; req1_addr = '0; req1_wdata = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset: outputs quiet even with a request pending.
    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b1;
    #1 check_outputs_zero("reset_outputs");
    req0_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_outputs_zero("idle_outputs");

    // WRITE 0x300 <- 0xA5 over old 0x11.
    preload(12'h300, 32'h11);
    exp_grant.push_back(1'b0);
    exp_wr.push_back(mk_wr(12'h300, 32'hA5));
    exp_rsp.push_back(mk_rsp(1'b0, 32'h11, 1'b0));
    issue(1'b0, OP_WR, 12'h300, 32'hA5);
    drain();

    // SET from port 1, then a zero-operand SET that must not write.
    preload(12'h300, 32'hF0);
    exp_grant.push_back(1'b1);
    exp_wr.push_back(mk_wr(12'h300, 32'hFF));
    exp_rsp.push_back(mk_rsp(1'b1, 32'hF0, 1'b0));
    issue(1'b1, OP_SET, 12'h300, 32'h0F);
    drain();
    preload(12'h300, 32'hF0);
    exp_grant.push_back(1'b1);
    exp_rsp.push_back(mk_rsp(1'b1, 32'hF0, 1'b0));
    issue(1'b1, OP_SET, 12'h300, 32'h0);
    drain();

    // CLEAR and READ.
    preload(12'h004, 32'hFF);
    exp_grant.push_back(1'b0);
    exp_wr.push_back(mk_wr(12'h004, 32'hF0));
    exp_rsp.push_back(mk_rsp(1'b0, 32'hFF, 1'b0));
    issue(1'b0, OP_CLR, 12'h004, 32'h0F);
    drain();
    preload(12'h010, 32'h12345678);
    exp_grant.push_back(1'b1);
    exp_rsp.push_back(mk_rsp(1'b1, 32'h12345678, 1'b0));
    issue(1'b1, OP_RD, 12'h010, 32'hFFFF_FFFF);
    drain();

    // Read-only region.
    preload(12'hC00, 32'hDEAD);
    exp_grant.push_back(1'b0);
    exp_rsp.push_back(mk_rsp(1'b0, 32'hDEAD, 1'b1));
    issue(1'b0, OP_WR, 12'hC00, 32'h55);
    drain();
    preload(12'hC05, 32'h3);
    exp_grant.push_back(1'b0);
    exp_rsp.push_back(mk_rsp(1'b0, 32'h3, 1'b0));
    issue(1'b0, OP_SET, 12'hC05, 32'h0);
    drain();
    exp_grant.push_back(1'b1);
    exp_rsp.push_back(mk_rsp(1'b1, 32'h3, 1'b1));
    issue(1'b1, OP_CLR, 12'hC05, 32'h1);
    drain();
    exp_grant.push_back(1'b0);
    exp_rsp.push_back(mk_rsp(1'b0, 32'hDEAD, 1'b0));
    issue(1'b0, OP_RD, 12'hC00, 32'h0);
    drain();

    // Starvation: both ports continuously valid.
    preload(12'h020, 32'hAAAA0000);
    preload(12'h024, 32'hBBBB1111);
    seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    foreach (seq[k]) begin
      exp_grant.push_back(seq[k]);
      exp_rsp.push_back(mk_rsp(seq[k], seq[k] ? 32'hBBBB1111 : 32'hAAAA0000, 1'b0));
    end
    @(negedge clk);
    req0_op = OP_RD; req0_addr = 12'h020; req0_wdata = '0; req0_valid = 1'b1;
    req1_op = OP_RD; req1_addr = 12'h024; req1_wdata = '0; req1_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 10; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        n++;
        if (n == 10) begin
          @(posedge clk);
          #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      if (n < 10) @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("starve_grants", 64'(n), 64'd10);
    drain();

    // Response stall: port 0 holds off ready for 5 cycles while port 1 waits.
    preload(12'h030, 32'h77);
    preload(12'h034, 32'h88);
    rsp0_ready = 1'b0;
    exp_grant.push_back(1'b0);
    exp_rsp.push_back(mk_rsp(1'b0, 32'h77, 1'b0));
    exp_grant.push_back(1'b1);
    exp_rsp.push_back(mk_rsp(1'b1, 32'h88, 1'b0));
    issue(1'b0, OP_RD, 12'h030, 32'h0);
    req1_op = OP_RD; req1_addr = 12'h034; req1_wdata = '0; req1_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall_rsp_valid", 64'(rsp0_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", 64'(rsp0_valid), 64'd1);
      check("stall_no_grant", 64'(req1_ready | req0_ready), 64'd0);
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_idle_after_ready", 64'(req1_ready), 64'd1);
    check("stall_rsp_dropped", 64'(rsp0_valid), 64'd0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // Reset while in MODIFY drops the write and the response.
    preload(12'h040, 32'h01);
    exp_grant.push_back(1'b0);
    issue(1'b0, OP_WR, 12'h040, 32'h99);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_modify_no_wr", 64'(csr_wr_en), 64'd0);
    check_outputs_zero("rst_modify_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_grant.push_back(1'b0);
    exp_rsp.push_back(mk_rsp(1'b0, 32'h01, 1'b0));
    req0_op = OP_RD; req0_addr = 12'h040; req0_wdata = '0; req0_valid = 1'b1;
    #1;
    check("accept_after_rst", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    check("leftover_grant", 64'(exp_grant.size()), 64'd0);
    check("leftover_wr", 64'(exp_wr.size()), 64'd0);
    check("leftover_rsp", 64'(exp_rsp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
